// File: rtl/l2_sqrt_unit_if.sv
// Radicand-in / root-out handshake for the L2 square-root stage.
// The master drives operands; the slave returns root, remainder and a completion pulse.
interface l2_sqrt_unit_if #(
    parameter int IN_W = 20
);
    localparam int OUT_W = IN_W / 2;

    logic [IN_W-1:0]  f_in;
    logic             valid_in;
    logic             ready;
    logic [OUT_W-1:0] root;
    logic [OUT_W:0]   rem;
    logic             valid_out;

    modport master (
        output f_in, valid_in,
        input  ready, root, rem, valid_out
    );

    modport slave (
        input  f_in, valid_in,
        output ready, root, rem, valid_out
    );
endinterface

// File: rtl/l2_sqrt_unit.sv
// Iterative restoring integer square root, two radicand bits per cycle.
// Completes the L2 norm on the sum of squares from the upstream accumulator.
//
// state | meaning
// IDLE  | ready high, waiting for valid_in to capture a radicand
// CALC  | one restoring step per edge, OUT_W steps, then pulse valid_out
module l2_sqrt_unit #(
    parameter int IN_W = 20
) (
    input  logic          clk,
    input  logic          reset,
    l2_sqrt_unit_if.slave bus
);
    localparam int OUT_W = IN_W / 2;
    localparam int CW    = (OUT_W > 1) ? $clog2(OUT_W) : 1;
    localparam int RW    = OUT_W + 2;

    typedef enum logic {IDLE, CALC} state_t;

    state_t           state, state_next;
    logic [CW-1:0]    count;
    logic [IN_W-1:0]  rad;
    logic [OUT_W-1:0] proot;
    logic [RW-1:0]    prem;
    logic [OUT_W-1:0] root_q;
    logic [OUT_W:0]   rem_q;
    logic             valid_q;
    logic             armed;
    logic             accept;
    logic             done;

    logic [RW-1:0]    shifted;
    logic [RW-1:0]    trial;
    logic [RW-1:0]    prem_next;
    logic [OUT_W-1:0] proot_next;

    // armed blocks the edge that coincides with reset release from accepting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            armed <= 1'b0;
        end else begin
            state <= state_next;
            armed <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (bus.valid_in && armed) begin
                    accept     = 1'b1;
                    state_next = CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    done       = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Partial remainder never exceeds 2*partial_root, so its low OUT_W bits suffice here
    always_comb begin
        shifted    = {prem[OUT_W-1:0], rad[IN_W-1 -: 2]};
        trial      = shifted - {proot, 2'b01};
        prem_next  = trial[RW-1] ? shifted : trial;
        proot_next = {proot[OUT_W-2:0], ~trial[RW-1]};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count   <= '0;
            rad     <= '0;
            proot   <= '0;
            prem    <= '0;
            root_q  <= '0;
            rem_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (accept) begin
                rad   <= bus.f_in;
                proot <= '0;
                prem  <= '0;
                count <= CW'(OUT_W - 1);
            end else if (state == CALC) begin
                rad   <= {rad[IN_W-3:0], 2'b00};
                proot <= proot_next;
                prem  <= prem_next;
                count <= count - 1'b1;
                if (done) begin
                    root_q  <= proot_next;
                    rem_q   <= prem_next[OUT_W:0];
                    valid_q <= 1'b1;
                end
            end
        end
    end

    assign bus.ready     = (state == IDLE);
    assign bus.root      = root_q;
    assign bus.rem       = rem_q;
    assign bus.valid_out = valid_q;
endmodule

// File: tb/tb_l2_sqrt_unit.sv
// Self-checking bench for l2_sqrt_unit: vector table, hand-written corner sequences,
// and random operands checked against a plain-arithmetic floor-sqrt model.
module tb_l2_sqrt_unit;
    localparam int IN_W  = 20;
    localparam int OUT_W = IN_W / 2;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    l2_sqrt_unit_if #(.IN_W(IN_W)) bus ();
    l2_sqrt_unit #(.IN_W(IN_W)) dut (.clk(clk), .reset(reset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [IN_W-1:0]  f;
        logic [OUT_W-1:0] r;
        logic [OUT_W:0]   m;
    } vec_t;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: largest r with r*r <= f, remainder f - r*r
    function automatic void ref_sqrt(input longint f, output longint r, output longint m);
        r = 0;
        while ((r + 1) * (r + 1) <= f) r++;
        m = f - r * r;
    endfunction

    // Caller is in IDLE just after an edge; scrambles f_in during CALC when asked.
    task automatic run_op(input logic [IN_W-1:0] f, input longint er, input longint em,
                          input string name, input bit scramble);
        int  lat;
        bit  seen;
        bit  ready_ok;
        bus.f_in     = f;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        chk({name, " accept"}, bus.ready, 0);
        lat = 0; seen = 1'b0; ready_ok = 1'b1;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (scramble && k <= 9) begin
                bus.f_in     = IN_W'($urandom);
                bus.valid_in = 1'($urandom);
            end else begin
                bus.valid_in = 1'b0;
            end
            @(posedge clk); #1;
            if (bus.valid_out) begin
                seen = 1'b1;
                lat  = k;
            end else if (bus.ready) begin
                ready_ok = 1'b0;
            end
        end
        bus.valid_in = 1'b0;
        chk({name, " latency"}, lat, 10);
        chk({name, " ready_low"}, ready_ok, 1);
        chk({name, " root"}, bus.root, er);
        chk({name, " rem"}, bus.rem, em);
        chk({name, " ready_at_pulse"}, bus.ready, 1);
        @(posedge clk); #1;
        chk({name, " pulse_width"}, bus.valid_out, 0);
        chk({name, " root_hold"}, bus.root, er);
    endtask

    initial begin
        vec_t   tbl[6];
        longint er, em;
        int     t[3];
        logic [IN_W-1:0] ops[3];
        longint exp_r[3], exp_m[3];
        bit     hold_ok, seen, extra;

        n_checks = 0;
        n_fail   = 0;
        tbl[0] = '{f: 20'h00000, r: 10'd0,    m: 11'd0};
        tbl[1] = '{f: 20'h00064, r: 10'd10,   m: 11'd0};
        tbl[2] = '{f: 20'h3F804, r: 10'd510,  m: 11'd0};
        tbl[3] = '{f: 20'hFFFFF, r: 10'd1023, m: 11'd2046};
        tbl[4] = '{f: 20'h00065, r: 10'd10,   m: 11'd1};
        tbl[5] = '{f: 20'd144,   r: 10'd12,   m: 11'd0};

        reset        = 1'b0;
        bus.f_in     = '0;
        bus.valid_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset ready", bus.ready, 1);
        chk("reset valid_out", bus.valid_out, 0);
        chk("reset root", bus.root, 0);
        chk("reset rem", bus.rem, 0);

        // valid_in present on the edge that releases reset must be ignored
        bus.f_in     = 20'd100;
        bus.valid_in = 1'b1;
        @(posedge clk);
        reset = 1'b1;
        #1;
        bus.valid_in = 1'b0;
        chk("release_edge not_accepted", bus.ready, 1);
        extra = 1'b0;
        repeat (14) begin
            @(posedge clk); #1;
            if (bus.valid_out) extra = 1'b1;
        end
        chk("release_edge no_result", extra, 0);

        foreach (tbl[i])
            run_op(tbl[i].f, tbl[i].r, tbl[i].m, $sformatf("vec%0d", i), 1'b0);

        // Back-to-back with valid_in held: 16, 17, 99
        ops[0] = 20'd16; ops[1] = 20'd17; ops[2] = 20'd99;
        exp_r[0] = 4; exp_m[0] = 0;
        exp_r[1] = 4; exp_m[1] = 1;
        exp_r[2] = 9; exp_m[2] = 18;
        bus.f_in     = ops[0];
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.f_in = ops[1];
        hold_ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            seen = 1'b0;
            t[i] = 0;
            for (int k = 1; k <= 20 && !seen; k++) begin
                @(posedge clk); #1;
                if (bus.valid_out) begin
                    seen = 1'b1;
                    t[i] = k;
                end else if (i > 0 && bus.root != 10'(exp_r[i-1])) begin
                    hold_ok = 1'b0;
                end
            end
            chk($sformatf("b2b%0d latency", i), t[i], 10);
            chk($sformatf("b2b%0d root", i), bus.root, exp_r[i]);
            chk($sformatf("b2b%0d rem", i), bus.rem, exp_m[i]);
            @(posedge clk); #1;
            chk($sformatf("b2b%0d pulse_width", i), bus.valid_out, 0);
            chk($sformatf("b2b%0d ready_after", i), bus.ready, (i < 2) ? 0 : 1);
            if (i == 0) bus.f_in = ops[2];
            if (i == 1) bus.valid_in = 1'b0;
        end
        chk("b2b root_hold", hold_ok, 1);

        // Random operands with f_in/valid_in scrambled during CALC
        for (int n = 0; n < 24; n++) begin
            logic [IN_W-1:0] f;
            f = IN_W'($urandom);
            if (n == 0) f = 20'hFFFFE;
            if (n == 1) f = 20'd1;
            ref_sqrt(longint'(f), er, em);
            run_op(f, er, em, $sformatf("rand%0d", n), 1'b1);
        end

        // Reset mid-CALC discards the operand; 144 afterwards runs at full latency
        bus.f_in     = 20'hFFFFF;
        bus.valid_in = 1'b1;
        @(posedge clk); #1;
        bus.valid_in = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk("midreset root", bus.root, 0);
        chk("midreset rem", bus.rem, 0);
        chk("midreset valid_out", bus.valid_out, 0);
        chk("midreset ready", bus.ready, 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("after_reset no_stale", bus.valid_out, 0);
        run_op(20'd144, 12, 0, "post_reset144", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
